// File: rtl/wav_stream_pkg.sv
// Shared stream definitions used by the counter source, this FIFO and the drain.
package wav_stream_pkg;

    // Default stream data width in bits.
    localparam int STREAM_DW = 8;

    // One stream data word.
    typedef logic [STREAM_DW-1:0] stream_data_t;

endpackage : wav_stream_pkg

// File: rtl/wav_stream_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module wav_stream_fifo_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write the incoming word into the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : wav_stream_fifo_mem

// File: rtl/wav_stream_fifo.sv
// Synchronous valid/ready stream FIFO with occupancy and peak-occupancy
// reporting. Data passes through unmodified and in order; no empty bypass.
module wav_stream_fifo
    import wav_stream_pkg::*;
#(
    parameter int DW    = STREAM_DW,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ctl_clr,
    input  logic                     rx_tvalid,
    output logic                     rx_tready,
    input  logic [DW-1:0]            rx_tdata,
    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic [DW-1:0]            tx_tdata,
    output logic [$clog2(DEPTH):0]   sts_cnt,
    output logic [$clog2(DEPTH):0]   sts_max
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    logic [AW:0] cnt_r;
    logic [AW:0] max_r;
    logic        en_r;

    logic        full_s;
    logic        push_s;
    logic        pop_s;
    logic [AW:0] cnt_nxt_s;
    logic [AW:0] max_nxt_s;

    // Full when wrap bits differ and index bits match; derived only from
    // registered pointers so rx_tready never depends on tx_tready.
    assign full_s    = (wptr_r[AW] != rptr_r[AW]) &&
                       (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign rx_tready = en_r & ~full_s;
    assign tx_tvalid = (cnt_r != '0);
    assign push_s    = rx_tvalid & rx_tready;
    assign pop_s     = tx_tvalid & tx_tready;
    assign sts_cnt   = cnt_r;
    assign sts_max   = max_r;

    wav_stream_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wptr_r[AW-1:0]),
        .wdata (rx_tdata),
        .raddr (rptr_r[AW-1:0]),
        .rdata (tx_tdata)
    );

    // Next occupancy and next watermark from this cycle's handshakes.
    always_comb begin
        cnt_nxt_s = cnt_r;
        max_nxt_s = max_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + (AW+1)'(1);
            2'b01:   cnt_nxt_s = cnt_r - (AW+1)'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
        if (ctl_clr) begin
            max_nxt_s = cnt_nxt_s;
        end else if (cnt_nxt_s > max_r) begin
            max_nxt_s = cnt_nxt_s;
        end else begin
            max_nxt_s = max_r;
        end
    end

    // Input enable: held low in reset, raised on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r <= 1'b0;
        end else begin
            en_r <= 1'b1;
        end
    end

    // Pointer advance on accepted push / pop; both may move in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + (AW+1)'(1);
            end
        end
    end

    // Occupancy and peak-occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            max_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
            max_r <= max_nxt_s;
        end
    end

endmodule : wav_stream_fifo

// File: tb/tb_wav_stream_fifo.sv
// Directed and randomised checks of wav_stream_fifo (DW=8, DEPTH=4) against a
// small queue model kept by the bench.
module tb_wav_stream_fifo;

    logic       clk;
    logic       rst;
    logic       ctl_clr;
    logic       rx_tvalid;
    logic       rx_tready;
    logic [7:0] rx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic [7:0] tx_tdata;
    logic [2:0] sts_cnt;
    logic [2:0] sts_max;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    logic [7:0] m_q [$];
    logic       m_en  = 1'b0;
    int         m_max = 0;
    int         m_pops = 0;
    int         m_pushes = 0;

    wav_stream_fifo #(.DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl_clr   (ctl_clr),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .rx_tdata  (rx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .tx_tdata  (tx_tdata),
        .sts_cnt   (sts_cnt),
        .sts_max   (sts_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model before the
    // edge, advance the model across the edge. Entered and left at a negedge.
    task automatic cycle(input logic rv, input logic [7:0] d, input logic tr, input logic clr);
        logic exp_rdy;
        logic do_push;
        logic do_pop;
        int   ncnt;
        rx_tvalid = rv;
        rx_tdata  = d;
        tx_tready = tr;
        ctl_clr   = clr;
        #1;
        exp_rdy = m_en && (m_q.size() < 4);
        chk("rx_tready", {31'd0, rx_tready}, {31'd0, exp_rdy});
        chk("tx_tvalid", {31'd0, tx_tvalid}, {31'd0, (m_q.size() != 0)});
        chk("sts_cnt", {29'd0, sts_cnt}, m_q.size());
        chk("sts_max", {29'd0, sts_max}, m_max);
        if (m_q.size() != 0) begin
            chk("tx_tdata", {24'd0, tx_tdata}, {24'd0, m_q[0]});
        end
        do_push = rv && exp_rdy;
        do_pop  = (m_q.size() != 0) && tr;
        if (do_pop) begin
            void'(m_q.pop_front());
            m_pops++;
        end
        if (do_push) begin
            m_q.push_back(d);
            m_pushes++;
        end
        ncnt = m_q.size();
        if (clr || ncnt > m_max) begin
            m_max = ncnt;
        end
        m_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pops0;
        int budget;
        rst       = 1'b0;
        ctl_clr   = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        tx_tready = 1'b0;

        // 1: reset state, then release and idle.
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy", {31'd0, rx_tready}, 32'd0);
        chk("rst_vld", {31'd0, tx_tvalid}, 32'd0);
        chk("rst_cnt", {29'd0, sts_cnt}, 32'd0);
        chk("rst_max", {29'd0, sts_max}, 32'd0);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_rdy_after_edge", {31'd0, rx_tready}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 2: fill with 0x00..0x03, drain stalled.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
        end
        chk("t2_cnt", {29'd0, sts_cnt}, 32'd4);
        chk("t2_rdy", {31'd0, rx_tready}, 32'd0);
        chk("t2_max", {29'd0, sts_max}, 32'd4);
        chk("t2_data", {24'd0, tx_tdata}, 32'h00);
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        chk("t2_hold_data", {24'd0, tx_tdata}, 32'h00);
        chk("t2_hold_cnt", {29'd0, sts_cnt}, 32'd4);

        // 3: pop from full with push offered; pop-only first.
        cycle(1'b1, 8'h04, 1'b1, 1'b0);
        chk("t3_cnt", {29'd0, sts_cnt}, 32'd3);
        chk("t3_data", {24'd0, tx_tdata}, 32'h01);
        cycle(1'b1, 8'h04, 1'b1, 1'b0);
        chk("t3_cnt_both", {29'd0, sts_cnt}, 32'd3);
        chk("t3_data2", {24'd0, tx_tdata}, 32'h02);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t3_empty", {31'd0, tx_tvalid}, 32'd0);

        // 4: continuous streaming of a counter, pointers wrap many times.
        pops0 = m_pops;
        for (int i = 0; i < 1024; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
        end
        chk("t4_cnt", {29'd0, sts_cnt}, 32'd1);
        chk("t4_pops", m_pops - pops0, 32'd1023);
        chk("t4_last", {24'd0, tx_tdata}, 32'hFF);

        // 5: random traffic, then stall to full, then clear the watermark.
        pops0  = m_pushes;
        budget = 0;
        while ((m_pushes - pops0) < 1000 && budget < 20000) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            budget++;
        end
        chk("t5_words", m_pushes - pops0, 32'd1000);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        end
        chk("t5_stall_cnt", {29'd0, sts_cnt}, 32'd4);
        chk("t5_stall_max", {29'd0, sts_max}, 32'd4);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t5_clr_cnt", {29'd0, sts_cnt}, 32'd3);
        chk("t5_clr_max", {29'd0, sts_max}, 32'd3);

        // 6: reset with three words stored.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        chk("t6_pre_cnt", {29'd0, sts_cnt}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_vld", {31'd0, tx_tvalid}, 32'd0);
        chk("t6_rst_cnt", {29'd0, sts_cnt}, 32'd0);
        chk("t6_rst_max", {29'd0, sts_max}, 32'd0);
        chk("t6_rst_rdy", {31'd0, rx_tready}, 32'd0);
        m_q.delete();
        m_en  = 1'b0;
        m_max = 0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t6_first_data", {24'd0, tx_tdata}, 32'hA5);
        chk("t6_first_cnt", {29'd0, sts_cnt}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_drained", {31'd0, tx_tvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_wav_stream_fifo
